// File: rtl/complex_divide_seq_pkg.sv
// complex_divide_seq_pkg: shared width default and FSM state encoding for the complex divider
package complex_divide_seq_pkg;
  localparam int COMPLEX_WIDTH = 16;
  typedef enum logic [2:0] {S_IDLE, S_PREP, S_DIV, S_FIX, S_DONE} state_t;
endpackage

// File: rtl/complex_divide_seq_udiv.sv
// seq_udiv: unsigned restoring divider, one quotient bit per cycle, done after exactly N steps
// Ports: clk, rst_n (async active-low), load (capture operands, restart),
//        dividend/divisor [N-1:0], quotient [N-1:0], done (N steps completed)
module seq_udiv #(
  parameter int N = 33
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] quotient,
  output logic         done
);
  localparam int CW = $clog2(N + 1);
  logic [N-1:0]  r_rem, r_quo, r_dsr;
  logic [CW-1:0] r_cnt;
  logic [N:0]    w_sh, w_diff;
  // Dividend bits shift out of the quotient register into the partial remainder
  assign w_sh     = {r_rem, r_quo[N-1]};
  assign w_diff   = w_sh - {1'b0, r_dsr};
  assign done     = r_cnt == CW'(N);
  assign quotient = r_quo;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_rem <= '0;
      r_quo <= '0;
      r_dsr <= '0;
      r_cnt <= CW'(N);
    end else if (load) begin
      r_rem <= '0;
      r_quo <= dividend;
      r_dsr <= divisor;
      r_cnt <= '0;
    end else if (!done) begin
      r_rem <= w_diff[N] ? w_sh[N-1:0] : w_diff[N-1:0];
      r_quo <= {r_quo[N-2:0], ~w_diff[N]};
      r_cnt <= r_cnt + 1'b1;
    end
endmodule

// File: rtl/complex_divide_seq.sv
// complex_divide_seq: sequential complex divider q = a*conj(b)/|b|^2, truncating and saturating
// Ports: clk, rst_n (async active-low); in_valid/in_ready with a, b (Re high half, Im low half);
//        out_valid/out_ready with q, div_by_zero and sat, all held until transfer
module complex_divide_seq
  import complex_divide_seq_pkg::*;
#(
  parameter int WIDTH = COMPLEX_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] a,
  input  logic [2*WIDTH-1:0] b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] q,
  output logic               div_by_zero,
  output logic               sat
);
  localparam int N = 2*WIDTH + 1;
  localparam logic [N-1:0] LIM_P = N'((64'd1 << (WIDTH-1)) - 64'd1);
  localparam logic [N-1:0] LIM_N = N'(64'd1 << (WIDTH-1));
  state_t r_state, w_next;
  logic signed [WIDTH-1:0] r_ar, r_ai, r_br, r_bi;
  logic signed [N-1:0] w_ar, w_ai, w_br, w_bi, w_nr, w_ni;
  logic [N-1:0] w_den, w_anr, w_ani, w_qr, w_qi;
  logic [WIDTH-1:0] w_qre, w_qim;
  logic [2*WIDTH-1:0] r_q;
  logic r_snr, r_sni, r_dbz, r_sat, w_load, w_done_r, w_done_i, w_ovr_r, w_ovr_i;
  // Operands widened to 2W+1 so the sum of products cannot overflow
  assign w_ar   = r_ar;
  assign w_ai   = r_ai;
  assign w_br   = r_br;
  assign w_bi   = r_bi;
  assign w_nr   = w_ar*w_br + w_ai*w_bi;
  assign w_ni   = w_ai*w_br - w_ar*w_bi;
  assign w_den  = w_br*w_br + w_bi*w_bi;
  assign w_anr  = w_nr[N-1] ? -w_nr : w_nr;
  assign w_ani  = w_ni[N-1] ? -w_ni : w_ni;
  assign w_load = r_state == S_PREP && w_den != '0;
  seq_udiv #(.N(N)) u_div_re (.clk(clk), .rst_n(rst_n), .load(w_load), .dividend(w_anr),
                              .divisor(w_den), .quotient(w_qr), .done(w_done_r));
  seq_udiv #(.N(N)) u_div_im (.clk(clk), .rst_n(rst_n), .load(w_load), .dividend(w_ani),
                              .divisor(w_den), .quotient(w_qi), .done(w_done_i));
  // Negative results may reach one step further than positive ones before clipping
  assign w_ovr_r = w_qr > (r_snr ? LIM_N : LIM_P);
  assign w_ovr_i = w_qi > (r_sni ? LIM_N : LIM_P);
  assign w_qre   = w_ovr_r ? (r_snr ? LIM_N[WIDTH-1:0] : LIM_P[WIDTH-1:0])
                           : (r_snr ? -w_qr[WIDTH-1:0] : w_qr[WIDTH-1:0]);
  assign w_qim   = w_ovr_i ? (r_sni ? LIM_N[WIDTH-1:0] : LIM_P[WIDTH-1:0])
                           : (r_sni ? -w_qi[WIDTH-1:0] : w_qi[WIDTH-1:0]);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_IDLE;
    else r_state <= w_next;
  // A zero divisor skips the cores and goes through FIX so its result is presented two edges after accept
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = in_valid ? S_PREP : S_IDLE;
      S_PREP:  w_next = w_den == '0 ? S_FIX : S_DIV;
      S_DIV:   w_next = (w_done_r & w_done_i) ? S_FIX : S_DIV;
      S_FIX:   w_next = S_DONE;
      S_DONE:  w_next = out_ready ? S_IDLE : S_DONE;
      default: w_next = S_IDLE;
    endcase
  end
  always_comb begin
    in_ready    = r_state == S_IDLE;
    out_valid   = r_state == S_DONE;
    q           = r_q;
    div_by_zero = r_dbz;
    sat         = r_sat;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_ar  <= '0;
      r_ai  <= '0;
      r_br  <= '0;
      r_bi  <= '0;
      r_snr <= 1'b0;
      r_sni <= 1'b0;
      r_dbz <= 1'b0;
      r_sat <= 1'b0;
      r_q   <= '0;
    end else begin
      if (r_state == S_IDLE && in_valid) begin
        r_ar <= a[2*WIDTH-1:WIDTH];
        r_ai <= a[WIDTH-1:0];
        r_br <= b[2*WIDTH-1:WIDTH];
        r_bi <= b[WIDTH-1:0];
      end
      if (r_state == S_PREP) begin
        r_snr <= w_nr[N-1];
        r_sni <= w_ni[N-1];
        r_dbz <= w_den == '0;
      end
      if (r_state == S_FIX) begin
        r_q   <= r_dbz ? '0 : {w_qre, w_qim};
        r_sat <= ~r_dbz & (w_ovr_r | w_ovr_i);
      end
    end
endmodule

// File: tb/tb_complex_divide_seq.sv
// tb_complex_divide_seq: randomized + directed scoreboard bench for complex_divide_seq
module tb_complex_divide_seq;
  logic clk = 0, rst_n = 0, in_valid = 0, in_ready, out_valid, out_ready = 1, div_by_zero, sat;
  logic [31:0] a = 0, b = 0, q;
  int checks = 0, errors = 0, cyc = 0;
  bit rand_rdy = 0;
  typedef struct {logic [31:0] q; logic dbz; logic sat; int lat; int t;} exp_t;
  exp_t sb[$];

  complex_divide_seq #(.WIDTH(16)) dut (.clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in_ready(in_ready), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .q(q),
    .div_by_zero(div_by_zero), .sat(sat));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] pk(input int re, input int im);
    logic [31:0] r, i;
    r = re;
    i = im;
    return {r[15:0], i[15:0]};
  endfunction

  function automatic longint clip(input longint x, inout logic s);
    if (x > 32767) begin s = 1; return 32767; end
    if (x < -32768) begin s = 1; return -32768; end
    return x;
  endfunction

  // Reference: plain integer complex division, SV '/' truncates toward zero
  function automatic exp_t model(input logic [31:0] aa, input logic [31:0] bb);
    exp_t e;
    longint ar, ai, br, bi, nr, ni, den, qr, qi;
    logic s = 0;
    ar = longint'($signed(aa[31:16]));
    ai = longint'($signed(aa[15:0]));
    br = longint'($signed(bb[31:16]));
    bi = longint'($signed(bb[15:0]));
    nr = ar*br + ai*bi;
    ni = ai*br - ar*bi;
    den = br*br + bi*bi;
    e.t = 0;
    if (den == 0) begin
      e.q = 0; e.dbz = 1; e.sat = 0; e.lat = 2;
    end else begin
      qr = clip(nr / den, s);
      qi = clip(ni / den, s);
      e.q = pk(int'(qr), int'(qi)); e.dbz = 0; e.sat = s; e.lat = 36;
    end
    return e;
  endfunction

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  task automatic op(input logic [31:0] aa, input logic [31:0] bb);
    exp_t e;
    int n = 0;
    while (!in_ready && n < 500) begin @(posedge clk); #1; n++; end
    if (n == 500) chk("accept_timeout", 0, 1);
    a = aa; b = bb; in_valid = 1;
    @(posedge clk); #1;
    e = model(aa, bb);
    e.t = cyc;
    sb.push_back(e);
    in_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 2000) begin @(posedge clk); #1; n++; end
    if (n == 2000) chk("drain_timeout", sb.size(), 0);
  endtask

  initial forever begin
    @(posedge clk); #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: latency on first out_valid, stability while stalled, compare on transfer
  initial begin
    logic prev_v = 0, chk_ir = 0;
    logic [33:0] held = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin prev_v = 0; chk_ir = 0; end
      else begin
        if (chk_ir) chk("in_ready_after_xfer", in_ready, 1);
        chk_ir = 0;
        if (out_valid && !prev_v) begin
          if (sb.size() == 0) chk("unexpected_out_valid", 1, 0);
          else chk("latency", cyc - sb[0].t, sb[0].lat);
        end
        if (out_valid && prev_v) chk("stable_while_stalled", {q, div_by_zero, sat}, held);
        if (out_valid && out_ready) begin
          chk("in_ready_during_xfer", in_ready, 0);
          if (sb.size() != 0) begin
            chk("q", q, sb[0].q);
            chk("div_by_zero", div_by_zero, sb[0].dbz);
            chk("sat", sat, sb[0].sat);
            void'(sb.pop_front());
          end
          chk_ir = 1;
        end
        held = {q, div_by_zero, sat};
        prev_v = out_valid;
      end
    end
  end

  initial begin
    logic [31:0] da[9], db[9];
    int n;
    da = '{pk(10,95), pk(30,-30), pk(7,0), pk(-7,0), pk(0,8), pk(2,8), pk(-32768,-32768), pk(32767,-32768), pk(-1,1)};
    db = '{pk(3,-8),  pk(2,-6),   pk(2,0), pk(2,0),  pk(0,2), pk(0,0), pk(-1,0),           pk(0,-1),          pk(-32768,-32768)};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_q", q, 0);
    chk("rst_dbz", div_by_zero, 0);
    chk("rst_sat", sat, 0);
    rst_n = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 9; i++) begin op(da[i], db[i]); drain(); end
    // Backpressure: stall 10 cycles after out_valid
    out_ready = 0;
    op(pk(50,-20), pk(1,2));
    n = 0;
    while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
    chk("bp_out_valid", out_valid, 1);
    repeat (10) begin
      @(posedge clk); #1;
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid_hold", out_valid, 1);
    end
    out_ready = 1;
    drain();
    // Busy: second request during DIV is dropped
    op(pk(100,-3), pk(-4,5));
    repeat (5) @(posedge clk);
    #1;
    chk("busy_in_ready", in_ready, 0);
    a = pk(1,1); b = pk(1,0); in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    drain();
    repeat (40) @(posedge clk);
    #1;
    chk("busy_no_extra", out_valid, 0);
    // Reset in the middle of DIV
    op(pk(1000,2000), pk(3,4));
    repeat (9) @(posedge clk);
    #1;
    rst_n = 0;
    sb.delete();
    #1;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_q", q, 0);
    chk("mid_rst_flags", {div_by_zero, sat}, 0);
    @(posedge clk); #1;
    rst_n = 1;
    op(pk(4,1), pk(-2,-7));
    drain();
    // Random phase with random backpressure
    rand_rdy = 1;
    for (int i = 0; i < 40; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 3))
        0: rb = 0;
        1: rb = pk($urandom_range(0, 20) - 10, $urandom_range(0, 20) - 10);
        default: ;
      endcase
      op(ra, rb);
      drain();
    end
    rand_rdy = 0;
    out_ready = 1;
    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
